// File: rtl/i2c_temp_reader.sv
// I2C master that polls a 16-bit temperature register over a 4-tick-per-bit bus
// and publishes each good reading with a one-cycle data_valid pulse.
module i2c_temp_reader #(
  parameter logic [6:0] DEV_ADDR = 7'h4B,
  parameter int         POLL_GAP = 200
) (
  input  logic        clk_200kHz,
  input  logic        reset,
  input  logic        enable,
  inout  wire         SDA,
  output logic        SCL,
  output logic [15:0] temp_data,
  output logic        data_valid,
  output logic        ack_error,
  output logic        busy
);

  localparam int             GW        = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0]  GAP_LAST  = GW'(POLL_GAP - 1);
  localparam logic [7:0]     ADDR_BYTE = {DEV_ADDR, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_RD_MSB,
    S_M_ACK, S_RD_LSB, S_M_NACK, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   shift_q, shift_d;
  logic          nack_q, nack_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic [15:0]   temp_q, temp_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          sda_in;
  logic          slot_end;

  assign sda_in     = SDA;
  assign SDA        = sda_oe_q ? 1'b0 : 1'bz;
  assign SCL        = scl_q;
  assign temp_data  = temp_q;
  assign data_valid = valid_q;
  assign ack_error  = err_q;
  assign busy       = busy_q;
  assign slot_end   = (phase_q == 2'd3);

  always_ff @(posedge clk_200kHz) begin
    if (reset) begin
      state_q  <= S_IDLE;
      phase_q  <= 2'd0;
      bit_q    <= 3'd0;
      gap_q    <= '0;
      shift_q  <= 16'd0;
      nack_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      temp_q   <= 16'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      shift_q  <= shift_d;
      nack_q   <= nack_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      temp_q   <= temp_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Sequencing: every non-idle state is a whole number of 4-tick slots.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    nack_d  = nack_q;
    temp_d  = temp_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (state_q != S_IDLE) begin
      phase_d = phase_q + 2'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (gap_q == GAP_LAST) begin
          if (enable) begin
            state_d = S_START;
            gap_d   = '0;
            phase_d = 2'd0;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_START: begin
        if (slot_end) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (slot_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_ADDR_ACK;
        end
      end
      S_ADDR_ACK: begin
        if (slot_end) begin
          nack_d  = sda_in;
          err_d   = sda_in;
          state_d = sda_in ? S_STOP : S_RD_MSB;
        end
      end
      S_RD_MSB, S_RD_LSB: begin
        if (slot_end) begin
          shift_d = {shift_q[14:0], sda_in};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (state_q == S_RD_MSB) ? S_M_ACK : S_M_NACK;
        end
      end
      S_M_ACK: begin
        if (slot_end) state_d = S_RD_LSB;
      end
      S_M_NACK: begin
        if (slot_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (slot_end) begin
          state_d = S_IDLE;
          gap_d   = '0;
          if (!nack_q) begin
            temp_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus levels are decoded from the upcoming state/phase so the registered
  // pins line up with the phase they belong to.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_START: sda_oe_d = phase_d[1];
      S_ADDR: begin
        scl_d    = phase_d[1];
        sda_oe_d = ~ADDR_BYTE[3'd7 - bit_d];
      end
      S_ADDR_ACK, S_RD_MSB, S_RD_LSB, S_M_NACK: scl_d = phase_d[1];
      S_M_ACK: begin
        scl_d    = phase_d[1];
        sda_oe_d = 1'b1;
      end
      S_STOP: begin
        scl_d    = (phase_d != 2'd0);
        sda_oe_d = ~phase_d[1];
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_temp_reader.sv
// Directed bench for i2c_temp_reader: behavioural sensor slave, bus monitor,
// a table of read transactions and hand-written reset/enable sequences.
module tb_i2c_temp_reader;

  localparam int POLL_GAP = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  wire         sda;
  logic        scl;
  logic [15:0] temp_data;
  logic        data_valid;
  logic        ack_error;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Slave configuration, set by the stimulus between transactions.
  bit         slv_ack = 1'b1;
  logic [7:0] slv_msb = 8'h00;
  logic [7:0] slv_lsb = 8'h00;

  // Slave / monitor state.
  logic slv_drive = 1'b0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  int   nrise = 0;
  int   start_cnt = 0;
  int   stop_cnt = 0;
  logic mon_bits [0:26];

  pullup (sda);
  assign sda = slv_drive ? 1'b0 : 1'bz;

  i2c_temp_reader #(.DEV_ADDR(7'h4B), .POLL_GAP(POLL_GAP)) dut (
    .clk_200kHz (clk),
    .reset      (reset),
    .enable     (enable),
    .SDA        (sda),
    .SCL        (scl),
    .temp_data  (temp_data),
    .data_valid (data_valid),
    .ack_error  (ack_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor model: reacts to SCL edges seen at the falling clk edge.
  always @(negedge clk) begin
    int k;
    if (reset) begin
      slv_drive = 1'b0;
    end else begin
      if (prev_scl && scl && prev_sda && !sda) begin
        start_cnt = start_cnt + 1;
        nrise = 0;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        stop_cnt = stop_cnt + 1;
      end
      if (!prev_scl && scl) begin
        if (nrise < 27) mon_bits[nrise] = sda;
        nrise = nrise + 1;
      end
      if (prev_scl && !scl) begin
        k = nrise + 1;
        slv_drive = 1'b0;
        if (k == 9) slv_drive = slv_ack;
        else if (slv_ack && k >= 10 && k <= 17) slv_drive = !slv_msb[17 - k];
        else if (slv_ack && k >= 19 && k <= 26) slv_drive = !slv_lsb[26 - k];
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  typedef struct {
    bit          ack;
    logic [7:0]  msb;
    logic [7:0]  lsb;
    logic [15:0] exp_temp;
    bit          drop_en;
  } vec_t;

  vec_t vecs [0:4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_busy(input int exp_at, output int at);
    bit seen = 1'b0;
    at = -1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    chk("start_cycle", at, exp_at);
  endtask

  task automatic run_entry(input int idx, input int exp_start, output int dv_at, output int next_start);
    vec_t v;
    int start, s0, p0, dvn, ern, erc;
    logic [7:0] b;
    v = vecs[idx];
    slv_ack = v.ack;
    slv_msb = v.msb;
    slv_lsb = v.lsb;
    s0 = start_cnt;
    p0 = stop_cnt;
    dvn = 0; ern = 0; erc = -1; dv_at = -1;
    wait_busy(exp_start, start);
    if (v.drop_en) enable = 1'b0;
    while (cyc < start + 120) begin
      @(negedge clk);
      if (data_valid) begin dvn++; dv_at = cyc; end
      if (ack_error) begin ern++; erc = cyc; end
    end
    for (int i = 0; i < 8; i++) b[7 - i] = mon_bits[i];
    chk("addr_byte", b, 8'h97);
    chk("addr_ack_bit", mon_bits[8], !v.ack);
    chk("start_cond_count", start_cnt - s0, 1);
    chk("stop_cond_count", stop_cnt - p0, 1);
    chk("temp_data", temp_data, v.exp_temp);
    if (v.ack) begin
      for (int i = 0; i < 8; i++) b[7 - i] = mon_bits[9 + i];
      chk("msb_on_bus", b, v.msb);
      chk("master_ack_bit", mon_bits[17], 1'b0);
      for (int i = 0; i < 8; i++) b[7 - i] = mon_bits[18 + i];
      chk("lsb_on_bus", b, v.lsb);
      chk("master_nack_bit", mon_bits[26], 1'b1);
      chk("data_valid_count", dvn, 1);
      chk("data_valid_cycle", dv_at - start, 116);
      chk("ack_error_count", ern, 0);
      next_start = start + 116 + POLL_GAP;
    end else begin
      chk("ack_error_count", ern, 1);
      chk("ack_error_cycle", erc - start, 40);
      chk("data_valid_count", dvn, 0);
      next_start = start + 44 + POLL_GAP;
    end
    $display("txn %0d: start=%0d ack=%0b temp_data=0x%04h data_valid_pulses=%0d ack_error_pulses=%0d",
             idx, start, v.ack, temp_data, dvn, ern);
  endtask

  initial begin
    int rel, nxt, dv_at, prev_dv, start, good;

    vecs[0] = '{ack: 1'b1, msb: 8'h19, lsb: 8'h80, exp_temp: 16'h1980, drop_en: 1'b0};
    vecs[1] = '{ack: 1'b0, msb: 8'h55, lsb: 8'h55, exp_temp: 16'h1980, drop_en: 1'b0};
    vecs[2] = '{ack: 1'b1, msb: 8'h0C, lsb: 8'h40, exp_temp: 16'h0C40, drop_en: 1'b0};
    vecs[3] = '{ack: 1'b1, msb: 8'hFF, lsb: 8'h80, exp_temp: 16'hFF80, drop_en: 1'b0};
    vecs[4] = '{ack: 1'b1, msb: 8'hA5, lsb: 8'h5A, exp_temp: 16'hA55A, drop_en: 1'b1};

    // Power-on reset with enable high.
    reset = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    chk("rst_temp", temp_data, 16'h0);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_ack_error", ack_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    rel = cyc;

    nxt = rel + POLL_GAP;
    prev_dv = -1;
    for (int i = 0; i < 5; i++) begin
      run_entry(i, nxt, dv_at, nxt);
      if (i == 3) chk("dv_spacing", dv_at - prev_dv, POLL_GAP + 116);
      prev_dv = dv_at;
    end

    // Enable low after reset: bus must stay idle and released.
    enable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_temp", temp_data, 16'h0);
    good = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (scl === 1'b1 && sda === 1'b1 && busy === 1'b0) good++;
    end
    chk("idle_cycles_ok", good, 1000);
    vecs[0] = '{ack: 1'b1, msb: 8'h12, lsb: 8'h34, exp_temp: 16'h1234, drop_en: 1'b0};
    enable = 1'b1;
    run_entry(0, cyc + 1, dv_at, nxt);

    // Reset during RD_LSB bit 3.
    slv_ack = 1'b1;
    slv_msb = 8'h3C;
    slv_lsb = 8'hF0;
    wait_busy(nxt, start);
    while (cyc < start + 88) @(negedge clk);
    chk("pre_abort_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_scl", scl, 1'b1);
    chk("abort_sda", sda, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_temp", temp_data, 16'h0);
    chk("abort_valid", data_valid, 1'b0);
    reset = 1'b0;
    rel = cyc;
    wait_busy(rel + POLL_GAP, start);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
